// File: rtl/seq_divider.sv
// Sequential restoring divider: 15-bit unsigned dividend by 8-bit unsigned divisor,
// one quotient bit per clock, driven through a start/busy/done handshake.
module seq_divider #(
  parameter int DW = 15,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dvd_sr;
  logic [VW-1:0]   dvs;
  logic [VW:0]     prem;
  logic [VW+DW:0]  step;
  logic [VW:0]     step_prem;
  logic [DW-1:0]   step_q;
  logic            accept;

  // One restoring step: returns {next partial remainder, next shift register}.
  // The quotient bit enters the LSB as the dividend bits leave through the MSB.
  function automatic logic [VW+DW:0] restore_step(
    input logic [VW:0]   p,
    input logic [DW-1:0] sr,
    input logic [VW-1:0] d
  );
    logic [VW:0]   sh;
    logic [VW+1:0] diff;
    sh   = {p[VW-1:0], sr[DW-1]};
    diff = {1'b0, sh} - {2'b00, d};
    if (diff[VW+1])
      return {sh, sr[DW-2:0], 1'b0};
    else
      return {diff[VW:0], sr[DW-2:0], 1'b1};
  endfunction

  always_comb begin
    step      = restore_step(prem, dvd_sr, dvs);
    step_prem = step[VW+DW:DW];
    step_q    = step[DW-1:0];
    accept    = (state == IDLE) && start && (divisor != '0);
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              cnt      <= CW'(DW);
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= step_q;
            remainder <= step_prem[VW-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operands latched on accept, so input changes during RUN are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_sr <= dividend;
      dvs    <= divisor;
      prem   <= '0;
    end else if (state == RUN) begin
      dvd_sr <= step_q;
      prem   <= step_prem;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: table of hand-computed divisions plus
// sequences for ignored starts and asynchronous reset during RUN.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] dividend;
  logic [7:0]  divisor;
  logic [14:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks;
  int failures;

  typedef struct {
    logic [14:0] dvd;
    logic [7:0]  dvs;
    logic [14:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  seq_divider #(.DW(15), .VW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [14:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    int bcnt;
    launch(v.dvd, v.dvs);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_busy_cycles"}, bcnt, v.lat);
    chk({nm, "_quotient"}, int'(quotient), int'(v.q));
    chk({nm, "_remainder"}, int'(remainder), int'(v.r));
    chk({nm, "_div_zero"}, int'(div_zero), int'(v.dz));
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    chk({nm, "_done_falls"}, int'(done), 0);
    chk({nm, "_quotient_held"}, int'(quotient), int'(v.q));
  endtask

  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{dvd: 15'd64,     dvs: 8'd8,   q: 15'd8,      r: 8'd0,   dz: 1'b0, lat: 15};
    vecs[1] = '{dvd: 15'd32257,  dvs: 8'd255, q: 15'd126,    r: 8'd127, dz: 1'b0, lat: 15};
    vecs[2] = '{dvd: 15'd1046,   dvs: 8'd55,  q: 15'd19,     r: 8'd1,   dz: 1'b0, lat: 15};
    vecs[3] = '{dvd: 15'd5,      dvs: 8'd200, q: 15'd0,      r: 8'd5,   dz: 1'b0, lat: 15};
    vecs[4] = '{dvd: 15'h7FFF,   dvs: 8'd1,   q: 15'h7FFF,   r: 8'd0,   dz: 1'b0, lat: 15};
    vecs[5] = '{dvd: 15'd100,    dvs: 8'd0,   q: 15'h7FFF,   r: 8'd0,   dz: 1'b1, lat: 0};
    vecs[6] = '{dvd: 15'd1000,   dvs: 8'd10,  q: 15'd100,    r: 8'd0,   dz: 1'b0, lat: 15};
    vecs[7] = '{dvd: 15'd32767,  dvs: 8'd255, q: 15'd128,    r: 8'd127, dz: 1'b0, lat: 15};
    vecs[8] = '{dvd: 15'd0,      dvs: 8'd7,   q: 15'd0,      r: 8'd0,   dz: 1'b0, lat: 15};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_div_zero", int'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // start pulsed mid-run with new operands, then operands changed again
    launch(15'd1045, 8'd19);
    lat = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (k == 4) begin
        start    = 1'b1;
        dividend = 15'd9;
        divisor  = 8'd3;
      end
      if (k == 5) begin
        start    = 1'b0;
        dividend = 15'd1234;
        divisor  = 8'd0;
      end
      @(posedge clk);
      #1;
      lat = k;
    end
    chk("ignored_start_latency", lat, 15);
    chk("ignored_start_quotient", int'(quotient), 55);
    chk("ignored_start_remainder", int'(remainder), 0);
    chk("ignored_start_div_zero", int'(div_zero), 0);
    @(posedge clk);
    #1;
    chk("ignored_start_idle_busy", int'(busy), 0);

    // asynchronous reset in RUN cycle 7, checked before any further clock edge
    launch(15'd1045, 8'd19);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    chk("async_reset_quotient", int'(quotient), 0);
    chk("async_reset_remainder", int'(remainder), 0);
    chk("async_reset_div_zero", int'(div_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{dvd: 15'd200, dvs: 8'd7, q: 15'd28, r: 8'd4, dz: 1'b0, lat: 15}, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
